// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//
// Parallel-to-serial transmitter. A W-bit word is accepted over a valid/ready
// handshake. It is then shifted out one bit per accepted serial beat. An
// optional even-parity trailer bit can follow the data bits. The frame length
// and the counter width come only from the elaborated port width, so the
// block changes size correctly when W changes.
//
// Parameters:
//   W         data word width (1..64)
//   MSB_FIRST 1 = bit W-1 goes out first, 0 = bit 0 goes out first
//   PARITY    1 = append an even-parity bit (XOR of all data bits)
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_data is presented
//   in_ready   a word can be accepted this cycle (combinational)
//   in_data    word to transmit; sampled only on accept
//   ser_valid  ser_bit is valid
//   ser_ready  the sink takes ser_bit this cycle
//   ser_bit    current serial bit
//   ser_last   ser_bit is the final bit of the frame
// -----------------------------------------------------------------------------
module bit_serializer #(
   parameter int W         = 6,
   parameter int MSB_FIRST = 1,
   parameter int PARITY    = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         ser_valid,
   input  logic         ser_ready,
   output logic         ser_bit,
   output logic         ser_last
);

   // Frame length and counter width track the elaborated data width.
   localparam int FRAME_LEN = $bits(in_data) + PARITY;
   localparam int CNT_W     = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_LEN - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             parity_q, parity_d;
   logic             ser_valid_q, ser_valid_d;
   logic             ser_bit_q, ser_bit_d;
   logic             ser_last_q, ser_last_d;

   logic             accept;
   logic             beat;

   // Bit presented for a given register/counter state. The counter holds the
   // number of bits still to come after the current one, so a count of zero
   // with parity enabled is the parity slot.
   function automatic logic present_bit(input logic [W-1:0]     sr,
                                        input logic [CNT_W-1:0] cnt,
                                        input logic             par);
      logic b;
      if ((PARITY != 0) && (cnt == '0)) begin
         b = par;
      end else if (MSB_FIRST != 0) begin
         b = sr[W-1];
      end else begin
         b = sr[0];
      end
      return b;
   endfunction

   // A new word may enter while idle, or in the same cycle the last bit of
   // the current frame is taken, which makes frames run back-to-back.
   assign in_ready = (state_q == IDLE) || (ser_valid_q && ser_last_q && ser_ready);
   assign accept   = in_valid && in_ready;
   assign beat     = ser_valid_q && ser_ready;

   // NOTE: combinational logic uses blocking '=' so later statements see the
   // updated value; every variable gets a default at the top so no latch is
   // inferred on paths that do not assign it.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      parity_d = parity_q;

      if (beat) begin
         // Move the next bit toward the output end, filling with zeros.
         if (MSB_FIRST != 0) begin
            shreg_d = shreg_q << 1;
         end else begin
            shreg_d = shreg_q >> 1;
         end
         if (cnt_q == '0) begin
            state_d = IDLE;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end

      // An accept overrides the end-of-frame return to IDLE.
      if (accept) begin
         state_d  = SHIFT;
         shreg_d  = in_data;
         parity_d = ^in_data;
         cnt_d    = CNT_LOAD;
      end

      // Outputs are registered: derive them from the next-state values so
      // they line up with the state they describe.
      ser_valid_d = (state_d == SHIFT);
      ser_last_d  = ser_valid_d && (cnt_d == '0);
      ser_bit_d   = ser_valid_d ? present_bit(shreg_d, cnt_d, parity_d) : 1'b0;
   end

   // NOTE: sequential state uses non-blocking '<=' so all flops update from
   // pre-edge values; every flop, including the shift register, is reset so
   // a mid-frame reset leaves no stale bits behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         cnt_q       <= '0;
         parity_q    <= 1'b0;
         ser_valid_q <= 1'b0;
         ser_bit_q   <= 1'b0;
         ser_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         parity_q    <= parity_d;
         ser_valid_q <= ser_valid_d;
         ser_bit_q   <= ser_bit_d;
         ser_last_q  <= ser_last_d;
      end
   end

   assign ser_valid = ser_valid_q;
   assign ser_bit   = ser_bit_q;
   assign ser_last  = ser_last_q;

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//
// Directed bench for bit_serializer. Three instances share clk and rst_n:
//   dut_a  defaults (W=6, MSB first, no parity)
//   dut_b  W=6, LSB first, even parity
//   dut_c  W=1, no parity (single-bit frames)
// Inputs change 1 time unit after a rising edge; outputs are compared 2 time
// units after the edge, once the combinational in_ready has settled.
// Observed vectors are packed as {ser_valid, ser_bit, ser_last, in_ready}.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   logic       a_in_valid = 1'b0, a_ser_ready = 1'b0;
   logic [5:0] a_in_data  = '0;
   logic       a_in_ready, a_ser_valid, a_ser_bit, a_ser_last;

   logic       b_in_valid = 1'b0, b_ser_ready = 1'b0;
   logic [5:0] b_in_data  = '0;
   logic       b_in_ready, b_ser_valid, b_ser_bit, b_ser_last;

   logic       c_in_valid = 1'b0, c_ser_ready = 1'b0;
   logic [0:0] c_in_data  = '0;
   logic       c_in_ready, c_ser_valid, c_ser_bit, c_ser_last;

   int n_tests = 0;
   int n_fail  = 0;

   wire [3:0] a_obs = {a_ser_valid, a_ser_bit, a_ser_last, a_in_ready};
   wire [3:0] b_obs = {b_ser_valid, b_ser_bit, b_ser_last, b_in_ready};
   wire [3:0] c_obs = {c_ser_valid, c_ser_bit, c_ser_last, c_in_ready};

   always #5 clk = ~clk;

   bit_serializer #(.W(6), .MSB_FIRST(1), .PARITY(0)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .ser_valid(a_ser_valid), .ser_ready(a_ser_ready),
      .ser_bit(a_ser_bit), .ser_last(a_ser_last)
   );

   bit_serializer #(.W(6), .MSB_FIRST(0), .PARITY(1)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .ser_valid(b_ser_valid), .ser_ready(b_ser_ready),
      .ser_bit(b_ser_bit), .ser_last(b_ser_last)
   );

   bit_serializer #(.W(1), .MSB_FIRST(1), .PARITY(0)) dut_c (
      .clk(clk), .rst_n(rst_n),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
      .ser_valid(c_ser_valid), .ser_ready(c_ser_ready),
      .ser_bit(c_ser_bit), .ser_last(c_ser_last)
   );

   // Advance to 1 time unit after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({a_obs, b_obs, c_obs} !== 12'h111) begin
         n_fail++;
         $display("FAIL reset_immediate: got %h expected %h", {a_obs, b_obs, c_obs}, 12'h111);
      end
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (i == 3) rst_n = 1'b1;
         #1;
         n_tests++;
         if ({a_obs, b_obs, c_obs} !== 12'h111) begin
            n_fail++;
            $display("FAIL reset_idle cycle %0d: got %h expected %h", i, {a_obs, b_obs, c_obs}, 12'h111);
         end
      end
   endtask

   task automatic test_single_frame();
      logic [5:0] word = 6'b101100;
      logic [3:0] exp;
      cyc();
      a_in_data = word; a_in_valid = 1'b1; a_ser_ready = 1'b1;
      cyc();
      // Garbage on in_data after accept must not reach the frame.
      a_in_valid = 1'b0; a_in_data = 6'b010011;
      for (int i = 0; i < 6; i++) begin
         #1;
         exp = {1'b1, word[5-i], (i == 5), (i == 5)};
         n_tests++;
         if (a_obs !== exp) begin
            n_fail++;
            $display("FAIL single_frame bit %0d: got %b expected %b", i, a_obs, exp);
         end
         cyc();
      end
      #1;
      n_tests++;
      if (a_obs !== 4'b0001) begin
         n_fail++;
         $display("FAIL single_frame end: got %b expected %b", a_obs, 4'b0001);
      end
   endtask

   task automatic test_lsb_parity();
      // LSB-first bits of 6'b101100 then parity 1, indexed by beat number.
      logic [6:0] bits = 7'b1101100;
      logic [3:0] exp;
      cyc();
      b_in_data = 6'b101100; b_in_valid = 1'b1; b_ser_ready = 1'b1;
      cyc();
      b_in_valid = 1'b0; b_in_data = 6'b000000;
      for (int i = 0; i < 7; i++) begin
         #1;
         exp = {1'b1, bits[i], (i == 6), (i == 6)};
         n_tests++;
         if (b_obs !== exp) begin
            n_fail++;
            $display("FAIL lsb_parity bit %0d: got %b expected %b", i, b_obs, exp);
         end
         cyc();
      end
      #1;
      n_tests++;
      if (b_obs !== 4'b0001) begin
         n_fail++;
         $display("FAIL lsb_parity end: got %b expected %b", b_obs, 4'b0001);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp;
      logic       last;
      cyc();
      a_in_data = 6'h3F; a_in_valid = 1'b1; a_ser_ready = 1'b1;
      cyc();
      a_in_data = 6'h00;
      for (int k = 1; k <= 12; k++) begin
         if (k == 7) a_in_valid = 1'b0;
         #1;
         last = (k == 6) || (k == 12);
         exp  = {1'b1, (k <= 6), last, last};
         n_tests++;
         if (a_obs !== exp) begin
            n_fail++;
            $display("FAIL back_to_back cycle %0d: got %b expected %b", k, a_obs, exp);
         end
         cyc();
      end
      #1;
      n_tests++;
      if (a_obs !== 4'b0001) begin
         n_fail++;
         $display("FAIL back_to_back end: got %b expected %b", a_obs, 4'b0001);
      end
   endtask

   task automatic test_backpressure();
      // Per-cycle tables, index 0 = first cycle after accept.
      logic [8:0] rdy_v  = 9'b111110001;
      logic [8:0] bit_v  = 9'b100000001;
      logic [8:0] last_v = 9'b100000000;
      logic [3:0] exp;
      cyc();
      a_in_data = 6'b100001; a_in_valid = 1'b1; a_ser_ready = 1'b1;
      cyc();
      a_in_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         a_ser_ready = rdy_v[i];
         #1;
         exp = {1'b1, bit_v[i], last_v[i], last_v[i] & rdy_v[i]};
         n_tests++;
         if (a_obs !== exp) begin
            n_fail++;
            $display("FAIL backpressure cycle %0d: got %b expected %b", i + 1, a_obs, exp);
         end
         cyc();
      end
      #1;
      n_tests++;
      if (a_obs !== 4'b0001) begin
         n_fail++;
         $display("FAIL backpressure end: got %b expected %b", a_obs, 4'b0001);
      end
   endtask

   task automatic test_mid_frame_reset();
      logic [5:0] word = 6'b010101;
      logic [3:0] exp;
      cyc();
      a_in_data = 6'b111111; a_in_valid = 1'b1; a_ser_ready = 1'b1;
      cyc();
      a_in_valid = 1'b0;
      cyc();
      cyc();
      // Third bit is on the wire; reset between edges.
      #1;
      n_tests++;
      if (a_obs !== 4'b1100) begin
         n_fail++;
         $display("FAIL mid_reset pre: got %b expected %b", a_obs, 4'b1100);
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (a_obs !== 4'b0001) begin
         n_fail++;
         $display("FAIL mid_reset immediate: got %b expected %b", a_obs, 4'b0001);
      end
      cyc();
      rst_n = 1'b1;
      cyc();
      #1;
      n_tests++;
      if (a_obs !== 4'b0001) begin
         n_fail++;
         $display("FAIL mid_reset released: got %b expected %b", a_obs, 4'b0001);
      end
      a_in_data = word; a_in_valid = 1'b1;
      cyc();
      a_in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         exp = {1'b1, word[5-i], (i == 5), (i == 5)};
         n_tests++;
         if (a_obs !== exp) begin
            n_fail++;
            $display("FAIL mid_reset new bit %0d: got %b expected %b", i, a_obs, exp);
         end
         cyc();
      end
      #1;
      n_tests++;
      if (a_obs !== 4'b0001) begin
         n_fail++;
         $display("FAIL mid_reset end: got %b expected %b", a_obs, 4'b0001);
      end
   endtask

   task automatic test_single_bit();
      cyc();
      c_in_data = 1'b1; c_in_valid = 1'b1; c_ser_ready = 1'b1;
      cyc();
      c_in_data = 1'b0;
      #1;
      n_tests++;
      if (c_obs !== 4'b1111) begin
         n_fail++;
         $display("FAIL single_bit first: got %b expected %b", c_obs, 4'b1111);
      end
      cyc();
      c_in_valid = 1'b0;
      #1;
      n_tests++;
      if (c_obs !== 4'b1011) begin
         n_fail++;
         $display("FAIL single_bit second: got %b expected %b", c_obs, 4'b1011);
      end
      cyc();
      #1;
      n_tests++;
      if (c_obs !== 4'b0001) begin
         n_fail++;
         $display("FAIL single_bit end: got %b expected %b", c_obs, 4'b0001);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_lsb_parity();
      test_back_to_back();
      test_backpressure();
      test_mid_frame_reset();
      test_single_bit();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
      $fatal(1, "watchdog expired");
   end

endmodule
